// File: rtl/gps_corr_pkg.sv
// Shared definitions for the GPS correlator accumulator: default widths,
// the run-state enum, saturation limits and the dump-length helper.
package gps_corr_pkg;

  localparam int ACC_W_DEF  = 16;
  localparam int SAMP_W_DEF = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } corr_state_e;

  // Saturation limits for the default accumulator width.
  localparam logic signed [ACC_W_DEF-1:0] SAT_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic signed [ACC_W_DEF-1:0] SAT_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

  // Number of epochs per dump minus one; a length of zero behaves as one.
  function automatic logic [4:0] len_minus_one(input logic [4:0] len);
    logic [4:0] res_v;
    if (len == 5'd0) begin
      res_v = 5'd0;
    end else begin
      res_v = len - 5'd1;
    end
    return res_v;
  endfunction

endpackage

// File: rtl/corr_lane.sv
// One correlator lane: sign-multiply a sample by a +/-1 chip and accumulate.
// Build option: define CORR_ACC_SAT_EN to saturate instead of wrapping.
module corr_lane
  import gps_corr_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int SAMP_W = SAMP_W_DEF
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     clr,
  input  logic                     ld,
  input  logic                     add,
  input  logic                     samp_valid,
  input  logic signed [SAMP_W-1:0] samp,
  input  logic                     chip,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] samp_ext_s;
  logic signed [ACC_W-1:0] contrib_s;
  logic signed [ACC_W-1:0] sum_s;

  // Sign-extend the sample, then negate it when the chip is -1.
  always_comb begin
    samp_ext_s = {{(ACC_W-SAMP_W){samp[SAMP_W-1]}}, samp};
    if (chip) begin
      contrib_s = samp_ext_s;
    end else begin
      contrib_s = {ACC_W{1'b0}} - samp_ext_s;
    end
  end

`ifdef CORR_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX_C = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN_C = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W:0] wide_s;

  // Add with one guard bit and clamp to the signed range on overflow.
  always_comb begin
    wide_s = {acc_r[ACC_W-1], acc_r} + {contrib_s[ACC_W-1], contrib_s};
    if (wide_s[ACC_W] != wide_s[ACC_W-1]) begin
      if (wide_s[ACC_W]) begin
        sum_s = ACC_MIN_C;
      end else begin
        sum_s = ACC_MAX_C;
      end
    end else begin
      sum_s = wide_s[ACC_W-1:0];
    end
  end
`else
  // Plain two's-complement add; overflow wraps modulo 2^ACC_W.
  always_comb begin
    sum_s = acc_r + contrib_s;
  end
`endif

  // Accumulator register: clear, reload with this sample, or accumulate.
  always_ff @(posedge clk) begin
    if (res) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (clr) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (ld) begin
      if (samp_valid) begin
        acc_r <= contrib_s;
      end else begin
        acc_r <= {ACC_W{1'b0}};
      end
    end else if (add && samp_valid) begin
      acc_r <= sum_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/corr_accum.sv
// Early/prompt/late I/Q correlator accumulator with epoch-aligned dumps
// and a valid/ack handshake on the dump registers.
// Build option: CORR_ACC_SAT_EN selects saturating accumulators.
module corr_accum
  import gps_corr_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int SAMP_W = SAMP_W_DEF
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     en,
  input  logic [4:0]               int_len,
  input  logic                     samp_valid,
  input  logic signed [SAMP_W-1:0] i_samp,
  input  logic signed [SAMP_W-1:0] q_samp,
  input  logic                     pne,
  input  logic                     pnp,
  input  logic                     pnl,
  input  logic                     epoch,
  output logic signed [ACC_W-1:0]  ie,
  output logic signed [ACC_W-1:0]  qe,
  output logic signed [ACC_W-1:0]  ip,
  output logic signed [ACC_W-1:0]  qp,
  output logic signed [ACC_W-1:0]  il,
  output logic signed [ACC_W-1:0]  ql,
  output logic                     dump_valid,
  input  logic                     dump_ack,
  output logic                     overrun
);

  corr_state_e state_r;
  logic [4:0]  cnt_r;
  logic [4:0]  len_m1_s;
  logic        start_s;
  logic        dump_s;
  logic        clr_s;
  logic        ld_s;
  logic        add_s;
  logic [2:0]  chips_s;

  // Lane order: 0..2 are I early/prompt/late, 3..5 are Q early/prompt/late.
  logic signed [ACC_W-1:0] acc_s [6];

  assign chips_s = {pnl, pnp, pne};

  // Decode the per-cycle lane controls from state, enable and epoch.
  always_comb begin
    len_m1_s = len_minus_one(int_len);
    start_s  = 1'b0;
    dump_s   = 1'b0;
    clr_s    = 1'b0;
    add_s    = 1'b0;
    if (state_r == IDLE) begin
      start_s = en && epoch;
    end else begin
      if (!en) begin
        clr_s = 1'b1;
      end else begin
        dump_s = epoch && (cnt_r == len_m1_s);
        add_s  = !dump_s;
      end
    end
    ld_s = start_s || dump_s;
  end

  for (genvar k = 0; k < 6; k++) begin : g_lane
    corr_lane #(
      .ACC_W  (ACC_W),
      .SAMP_W (SAMP_W)
    ) u_lane (
      .clk        (clk),
      .res        (res),
      .clr        (clr_s),
      .ld         (ld_s),
      .add        (add_s),
      .samp_valid (samp_valid),
      .samp       ((k < 3) ? i_samp : q_samp),
      .chip       (chips_s[k % 3]),
      .acc        (acc_s[k])
    );
  end

  // Run state and count of epochs completed in the current dump interval.
  always_ff @(posedge clk) begin
    if (res) begin
      state_r <= IDLE;
      cnt_r   <= 5'd0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= 5'd0;
          if (en && epoch) begin
            state_r <= ACCUM;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCUM: begin
          if (!en) begin
            state_r <= IDLE;
            cnt_r   <= 5'd0;
          end else if (epoch) begin
            state_r <= ACCUM;
            if (dump_s) begin
              cnt_r <= 5'd0;
            end else begin
              cnt_r <= cnt_r + 5'd1;
            end
          end else begin
            state_r <= ACCUM;
            cnt_r   <= cnt_r;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 5'd0;
        end
      endcase
    end
  end

  // Dump registers and handshake; a dump beats an ack in the same cycle.
  always_ff @(posedge clk) begin
    if (res) begin
      ie         <= {ACC_W{1'b0}};
      ip         <= {ACC_W{1'b0}};
      il         <= {ACC_W{1'b0}};
      qe         <= {ACC_W{1'b0}};
      qp         <= {ACC_W{1'b0}};
      ql         <= {ACC_W{1'b0}};
      dump_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (dump_s) begin
      ie         <= acc_s[0];
      ip         <= acc_s[1];
      il         <= acc_s[2];
      qe         <= acc_s[3];
      qp         <= acc_s[4];
      ql         <= acc_s[5];
      dump_valid <= 1'b1;
      if (dump_valid && !dump_ack) begin
        overrun <= 1'b1;
      end else begin
        overrun <= overrun;
      end
    end else begin
      ie      <= ie;
      ip      <= ip;
      il      <= il;
      qe      <= qe;
      qp      <= qp;
      ql      <= ql;
      overrun <= overrun;
      if (dump_ack) begin
        dump_valid <= 1'b0;
      end else begin
        dump_valid <= dump_valid;
      end
    end
  end

endmodule

// File: doc/corr_accum.md
CORR_ACCUM -- requirements
Module: corr_accum

Interface
REQ-001 SHALL have parameter ACC_W, default 16: accumulator and output width in bits.
REQ-002 SHALL have parameter SAMP_W, default 3: signed I/Q sample width in bits.
REQ-003 SHALL have port clk, input, 1 bit: single clock, the only clock; all logic on its rising edge.
REQ-004 SHALL have port res, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have ports en (input, 1) and int_len (input, 5): run enable and code epochs per dump.
REQ-006 SHALL have ports samp_valid (input, 1), i_samp and q_samp (input, SAMP_W, signed): carrier-wiped baseband samples.
REQ-007 SHALL have ports pne, pnp and pnl (input, 1 each): early, prompt and late code chips from the code generator; 1 means +1, 0 means -1.
REQ-008 SHALL have port epoch, input, 1 bit: single-cycle pulse marking the first chip of a code period.
REQ-009 SHALL have ports ie, qe, ip, qp, il and ql (output, ACC_W, signed): registered dump values.
REQ-010 SHALL have ports dump_valid (output, 1), dump_ack (input, 1) and overrun (output, 1, sticky).

Function
REQ-011 SHALL run a state machine with two states, IDLE and ACCUM.
REQ-012 SHALL move from IDLE to ACCUM on the first epoch with en=1; no samples are accumulated while in IDLE.
REQ-013 SHALL return to IDLE from ACCUM when en=0, clearing the accumulators and epoch counter; dump registers are kept.
REQ-014 SHALL, in ACCUM on samp_valid, add to each lane +sample when its chip is 1 and -sample when its chip is 0.
- Lanes: I with pne/pnp/pnl feeds ie/ip/il; Q with pne/pnp/pnl feeds qe/qp/ql.
REQ-015 SHALL sign-extend samples to ACC_W before adding.
REQ-016 SHALL count epochs in ACCUM; int_len=0 is treated as 1.
REQ-017 SHALL perform a dump on the epoch that completes int_len periods:
- the six accumulators are copied to the outputs;
- the accumulators are reloaded with the current sample contribution (or 0 if samp_valid=0);
- the epoch counter is cleared.
REQ-018 SHALL treat a sample coincident with epoch as belonging to the new period, including on the IDLE to ACCUM transition.
REQ-019 SHALL assert dump_valid the cycle after the dumping epoch and hold it until a cycle with dump_ack=1; dump_valid drops the following cycle.
REQ-020 SHALL handle a dump that occurs while dump_valid=1 and dump_ack=0 as follows: the outputs are overwritten, dump_valid stays 1, and overrun sets.
REQ-021 SHALL let a dump win over a dump_ack in the same cycle, leaving dump_valid=1 with no overrun.
REQ-022 SHALL clear overrun only by res.

Reset
REQ-023 SHALL, on res=1, force state IDLE and clear the epoch counter, accumulators, all six outputs, dump_valid and overrun to 0.
REQ-024 SHALL let res take priority over every other event, including a mid-integration reset, which discards the partial sums.

Configuration
REQ-025 SHALL provide macro CORR_ACC_SAT_EN.
- Defined: each accumulator saturates at +(2^(ACC_W-1)-1) and -(2^(ACC_W-1)).
- Undefined: each accumulator wraps two's-complement modulo 2^ACC_W.

Structure
REQ-026 SHALL place ACC_W and SAMP_W defaults, the state enum {IDLE, ACCUM}, and the saturation limit constants in shared package gps_corr_pkg.
REQ-027 SHALL implement one sign-multiply/accumulate/saturate lane as sub-module corr_lane, instantiated six times.

Verification
REQ-028 SHALL cover: int_len=1, i_samp=+1, q_samp=0, pnp=1, pne=pnl=0, 1023 valid samples per epoch -> ip=1023, ie=il=-1023, all Q outputs 0, dump_valid 1 cycle after the 2nd epoch.
REQ-029 SHALL cover: int_len=0 versus int_len=1 with the same stimulus -> identical dump timing and values.
REQ-030 SHALL cover: int_len=3, i_samp=+3, pnp=1, 1023 samples per epoch -> ip=9207 in a single dump per 3 epochs.
REQ-031 SHALL cover: dump_ack held 0 across two dumps -> overrun=1 and outputs equal the second dump; dump_ack and epoch together -> dump_valid stays 1 and overrun stays 0.
REQ-032 SHALL cover: i_samp=+3 and pnp=1 for 12000 samples with ACC_W=16 -> ip=32767 with CORR_ACC_SAT_EN, ip=36000-65536=-29536 without.
REQ-033 SHALL cover: res pulsed mid-integration -> all outputs 0, state IDLE, and no samples accumulated until the next epoch with en=1.
